// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding, default sizing
// and the counter-width helper used to size the bit and gap counters.
package seq_bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } serState_t;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_GAP_CYCLES = 0;

  // Bits needed to hold the values 0..n-1, never fewer than one.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the "1001" sequence detector: accepts WIDTH-bit
// words over valid/ready and emits one bit per bit_tick on a registered ser_out.
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_tick,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = cntWidth(WIDTH);
  localparam int GW = cntWidth(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  serState_t        r_state;
  logic [WIDTH-1:0] r_shiftReg;
  logic [BW-1:0]    r_bitCnt;
  logic [GW-1:0]    r_gapCnt;
  logic             r_serOut;
  logic             r_serValid;
  logic             r_busy;
  logic             r_wordDone;

  serState_t        w_stateNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] w_shifted;
  logic [BW-1:0]    w_bitCntNext;
  logic [GW-1:0]    w_gapCntNext;
  logic             w_wordDoneNext;
  logic             w_serOutNext;
  logic             w_serValidNext;
  logic             w_busyNext;
  logic             w_lastBit;
  logic             w_accept;

  function automatic logic headBit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign w_shifted = MSB_FIRST ? {r_shiftReg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shiftReg[WIDTH-1:1]};

  // Without a gap, the cycle that consumes the last bit can already take the
  // next word so the detector sees an unbroken stream.
  assign w_lastBit = (r_state == SHIFT) && (r_bitCnt == BIT_LAST) && bit_tick;
  assign in_ready  = (r_state == IDLE) || (!HAS_GAP && w_lastBit);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_stateNext    = r_state;
    w_shiftNext    = r_shiftReg;
    w_bitCntNext   = r_bitCnt;
    w_gapCntNext   = r_gapCnt;
    w_wordDoneNext = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stateNext  = SHIFT;
          w_shiftNext  = in_data;
          w_bitCntNext = '0;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          if (r_bitCnt == BIT_LAST) begin
            w_wordDoneNext = 1'b1;
            w_bitCntNext   = '0;
            if (HAS_GAP) begin
              w_stateNext  = GAP;
              w_gapCntNext = '0;
              w_shiftNext  = '0;
            end else if (w_accept) begin
              w_shiftNext = in_data;
            end else begin
              w_stateNext = IDLE;
              w_shiftNext = '0;
            end
          end else begin
            w_shiftNext  = w_shifted;
            w_bitCntNext = r_bitCnt + BW'(1);
          end
        end
      end
      GAP: begin
        if (bit_tick) begin
          if (r_gapCnt == GAP_LAST) begin
            w_stateNext  = IDLE;
            w_gapCntNext = '0;
          end else begin
            w_gapCntNext = r_gapCnt + GW'(1);
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered.
  always_comb begin
    w_serValidNext = (w_stateNext == SHIFT);
    w_serOutNext   = w_serValidNext ? headBit(w_shiftNext) : IDLE_LEVEL;
    w_busyNext     = (w_stateNext != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_serOut   <= IDLE_LEVEL;
      r_serValid <= 1'b0;
      r_busy     <= 1'b0;
      r_wordDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shiftReg <= w_shiftNext;
      r_bitCnt   <= w_bitCntNext;
      r_gapCnt   <= w_gapCntNext;
      r_serOut   <= w_serOutNext;
      r_serValid <= w_serValidNext;
      r_busy     <= w_busyNext;
      r_wordDone <= w_wordDoneNext;
    end
  end

  assign ser_out   = r_serOut;
  assign ser_valid = r_serValid;
  assign busy      = r_busy;
  assign word_done = r_wordDone;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: two differently configured lanes, each driven with
// directed and random words and scored against an expected bit-stream queue.
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycles = 0;
  bit   laneDone [2];

  initial forever #5 clk = ~clk;

  function automatic void checkOutput(input string name, input int lane,
                                      input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL lane%0d %s: got %0d, expected %0d at %0t",
               lane, name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int   W     = (g == 0) ? 8 : 5;
    localparam bit   MSBF  = (g == 0);
    localparam int   GAPC  = (g == 0) ? 0 : 2;
    localparam logic IDLEL = (g == 0) ? 1'b0 : 1'b1;

    logic         rst = 1'b1;
    logic [W-1:0] inData = '0;
    logic         inValid = 1'b0;
    logic         bitTick = 1'b0;
    logic         inReady, serOut, serValid, busy, wordDone;
    int           tickMode = 0;
    int           tickPhase = 0;
    int           idle = 0;

    bit expQ[$];
    int gapLeft = 0;
    bit doneDue = 1'b0;
    bit mInFlight, mInGap, mReady, mDoneNext;

    seq_bit_serializer #(
      .WIDTH(W), .MSB_FIRST(MSBF), .GAP_CYCLES(GAPC), .IDLE_LEVEL(IDLEL)
    ) dut (
      .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
      .in_ready(inReady), .bit_tick(bitTick), .ser_out(serOut),
      .ser_valid(serValid), .busy(busy), .word_done(wordDone)
    );

    // Mode 0: every cycle, 1: every third cycle, 2: random, 3: frozen low.
    initial forever begin
      @(posedge clk);
      #1;
      tickPhase = (tickPhase == 2) ? 0 : tickPhase + 1;
      case (tickMode)
        0: bitTick = 1'b1;
        1: bitTick = (tickPhase == 0);
        2: bitTick = ($urandom_range(0, 1) == 1);
        default: bitTick = 1'b0;
      endcase
    end

    // Model: a word's bits enter the queue on accept and leave one per tick;
    // an emptied queue starts GAPC idle ticks before the next word may enter.
    initial forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("reset ser_out", g, serOut, IDLEL);
        checkOutput("reset ser_valid", g, serValid, 0);
        checkOutput("reset busy", g, busy, 0);
        checkOutput("reset word_done", g, wordDone, 0);
        checkOutput("reset in_ready", g, inReady, 1);
        expQ.delete();
        gapLeft = 0;
        doneDue = 1'b0;
      end else begin
        mInFlight = (expQ.size() > 0);
        mInGap    = !mInFlight && (gapLeft > 0);
        mReady    = (!mInFlight && !mInGap) ||
                    (GAPC == 0 && expQ.size() == 1 && bitTick);
        checkOutput("word_done", g, wordDone, doneDue);
        checkOutput("ser_valid", g, serValid, mInFlight);
        checkOutput("ser_out", g, serOut, mInFlight ? expQ[0] : IDLEL);
        checkOutput("busy", g, busy, mInFlight || mInGap);
        checkOutput("in_ready", g, inReady, mReady);
        mDoneNext = 1'b0;
        if (mInFlight && bitTick) begin
          void'(expQ.pop_front());
          if (expQ.size() == 0) begin
            mDoneNext = 1'b1;
            gapLeft   = GAPC;
          end
        end else if (mInGap && bitTick) begin
          gapLeft--;
        end
        if (inValid && mReady) begin
          for (int i = 0; i < W; i++)
            expQ.push_back(MSBF ? inData[W-1-i] : inData[i]);
        end
        doneDue = mDoneNext;
      end
    end

    task automatic waitCycles(input int n);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    endtask

    task automatic sendWord(input logic [W-1:0] data);
      bit accepted = 1'b0;
      int budget = 0;
      inData  = data;
      inValid = 1'b1;
      while (!accepted && budget < 400) begin
        @(negedge clk);
        if (inReady && rst) accepted = 1'b1;
        @(posedge clk);
        #1;
        budget++;
      end
      checkOutput("accept within budget", g, accepted, 1);
    endtask

    task automatic applyStimulus();
      #2 rst = 1'b0;
      inValid = 1'b1;
      inData  = W'(8'h5A);
      waitCycles(4);
      rst = 1'b1;
      sendWord(W'(8'h90));
      inValid = 1'b0;
      waitCycles(W + 6);
      sendWord(W'(8'h90));
      sendWord(W'(8'h09));
      inValid = 1'b0;
      waitCycles(W + 10);
      tickMode = 1;
      sendWord(W'(8'hA5));
      inValid = 1'b0;
      waitCycles(3 * W + 12);
      tickMode = 0;
      sendWord(W'(8'h3C));
      inValid = 1'b0;
      waitCycles(3);
      tickMode = 3;
      waitCycles(15);
      tickMode = 0;
      waitCycles(W + 6);
      sendWord(W'(8'hF0));
      inValid = 1'b0;
      waitCycles(3);
      rst = 1'b0;
      waitCycles(2);
      rst = 1'b1;
      sendWord(W'(8'h0F));
      inValid = 1'b0;
      waitCycles(W + 6);
      for (int n = 0; n < 40; n++) begin
        tickMode = int'($urandom_range(0, 2));
        sendWord(W'($urandom));
        idle = int'($urandom_range(0, 3));
        if (idle != 0) begin
          inValid = 1'b0;
          waitCycles(idle);
        end
      end
      inValid  = 1'b0;
      tickMode = 0;
      waitCycles(W + 10);
      laneDone[g] = 1'b1;
    endtask

    initial applyStimulus();
  end

  initial begin
    while (!(laneDone[0] && laneDone[1]) && cycles < 50000) begin
      @(posedge clk);
      cycles++;
    end
    checkOutput("lanes finished", 0, int'(laneDone[0] && laneDone[1]), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
